// File: rtl/reg_bus_endpoint_pkg.sv
// Shared definitions for the per-component register bus responder.
// Holds the byte-address map of the endpoint and the register data type.
// No ports: imported by reg_bus_endpoint and reg_ep_dbg_fifo.
package reg_bus_endpoint_pkg;

    typedef logic [31:0] reg_data_t;

    localparam logic [7:0] REG_EP_CFG_BASE   = 8'h00;
    localparam logic [7:0] REG_EP_CTR_BASE   = 8'h40;
    localparam logic [7:0] REG_EP_CTR_CLEAR  = 8'h60;
    localparam logic [7:0] REG_EP_CTR_ENABLE = 8'h64;
    localparam logic [7:0] REG_EP_DBG_COUNT  = 8'h70;
    localparam logic [7:0] REG_EP_DBG_POP    = 8'h74;
    localparam logic [7:0] REG_EP_DBG_DROPPED = 8'h78;

endpackage

// File: rtl/reg_ep_dbg_fifo.sv
// Synchronous debug-word FIFO for the register bus endpoint.
// Ports:
//   clk, rstn  : clock, synchronous active-low reset (contents are lost)
//   i_push     : push i_data; refused when full unless a pop happens too
//   i_data     : word to push
//   i_pop      : pop the head word; ignored when empty
//   o_head     : current head word (meaningless when o_count is 0)
//   o_count    : occupancy, 0 .. 2**LOG_DEPTH
//   o_full     : occupancy equals depth
module reg_ep_dbg_fifo
    import reg_bus_endpoint_pkg::*;
#(
    parameter int LOG_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_push,
    input  logic [31:0]        i_data,
    input  logic               i_pop,
    output logic [31:0]        o_head,
    output logic [LOG_DEPTH:0] o_count,
    output logic               o_full
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_COUNT = DEPTH[LOG_DEPTH:0];

    reg_data_t              r_mem [DEPTH];
    logic [LOG_DEPTH-1:0]   r_wptr;
    logic [LOG_DEPTH-1:0]   r_rptr;
    logic [LOG_DEPTH:0]     r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign w_full    = (r_count == FULL_COUNT);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointers are LOG_DEPTH bits wide, so they wrap modulo the depth.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/reg_bus_endpoint.sv
// Responder end of one component's register bus slot.
// Holds config registers, saturating event counters with per-counter
// enables, and a debug-word FIFO drained one word per DBG_POP read.
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   reg_bus_wvalid/waddr/wdata   : single-cycle write strobe, byte address, data
//   reg_bus_arvalid/araddr       : single-cycle read strobe, byte address
//   reg_bus_rvalid/rdata         : read response, one cycle after arvalid
//   cfg_out            : config registers, cfg i at [32i +: 32]
//   ctr_event          : per-counter increment strobes
//   dbg_valid/dbg_data : debug word push
module reg_bus_endpoint
    import reg_bus_endpoint_pkg::*;
#(
    parameter int        N_CFG         = 8,
    parameter int        N_CTR         = 4,
    parameter int        LOG_DBG_DEPTH = 4,
    parameter reg_data_t UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  reg_bus_wvalid,
    input  logic [7:0]            reg_bus_waddr,
    input  logic [31:0]           reg_bus_wdata,
    input  logic                  reg_bus_arvalid,
    input  logic [7:0]            reg_bus_araddr,
    output logic                  reg_bus_rvalid,
    output logic [31:0]           reg_bus_rdata,
    output logic [N_CFG*32-1:0]   cfg_out,
    input  logic [N_CTR-1:0]      ctr_event,
    input  logic                  dbg_valid,
    input  logic [31:0]           dbg_data
);

    // Decoding works on word addresses; the byte-lane bits are ignored.
    localparam logic [5:0] CFG_WORD     = REG_EP_CFG_BASE[7:2];
    localparam logic [5:0] CTR_WORD     = REG_EP_CTR_BASE[7:2];
    localparam logic [5:0] CLEAR_WORD   = REG_EP_CTR_CLEAR[7:2];
    localparam logic [5:0] ENABLE_WORD  = REG_EP_CTR_ENABLE[7:2];
    localparam logic [5:0] COUNT_WORD   = REG_EP_DBG_COUNT[7:2];
    localparam logic [5:0] POP_WORD     = REG_EP_DBG_POP[7:2];
    localparam logic [5:0] DROPPED_WORD = REG_EP_DBG_DROPPED[7:2];

    reg_data_t          r_cfg [N_CFG];
    logic [N_CTR-1:0]   r_ctr_en;
    reg_data_t          r_dropped;
    logic               r_rvalid;
    reg_data_t          r_rdata;

    logic [5:0]             w_wword;
    logic [5:0]             w_rword;
    logic [3:0]             w_unused_addr_bits;
    logic                   w_ctr_clear;
    logic                   w_pop_req;
    logic                   w_drop;
    reg_data_t              w_ctr [N_CTR];
    reg_data_t              w_rd_data;
    logic [31:0]            w_dbg_head;
    logic [LOG_DBG_DEPTH:0] w_dbg_count;
    logic                   w_dbg_full;

    assign w_wword            = reg_bus_waddr[7:2];
    assign w_rword            = reg_bus_araddr[7:2];
    assign w_unused_addr_bits = {reg_bus_waddr[1:0], reg_bus_araddr[1:0]};
    assign w_ctr_clear        = reg_bus_wvalid && (w_wword == CLEAR_WORD);
    assign w_pop_req          = reg_bus_arvalid && (w_rword == POP_WORD);

    // A full FIFO is never empty, so a pop request in the same cycle always
    // frees a slot and the push is not lost.
    assign w_drop = dbg_valid && w_dbg_full && !w_pop_req;

    reg_ep_dbg_fifo #(
        .LOG_DEPTH (LOG_DBG_DEPTH)
    ) u_dbg_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (dbg_valid),
        .i_data  (dbg_data),
        .i_pop   (w_pop_req),
        .o_head  (w_dbg_head),
        .o_count (w_dbg_count),
        .o_full  (w_dbg_full)
    );

    // Config registers, counter enables and the dropped-push counter.
    // A DBG_DROPPED write wins over a simultaneous drop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_CFG; i++) r_cfg[i] <= '0;
            r_ctr_en  <= '1;
            r_dropped <= '0;
        end else begin
            for (int i = 0; i < N_CFG; i++) begin
                if (reg_bus_wvalid && (w_wword == CFG_WORD + 6'(i)))
                    r_cfg[i] <= reg_bus_wdata;
            end
            if (reg_bus_wvalid && (w_wword == ENABLE_WORD))
                r_ctr_en <= reg_bus_wdata[N_CTR-1:0];
            if (reg_bus_wvalid && (w_wword == DROPPED_WORD))
                r_dropped <= '0;
            else if (w_drop && (r_dropped != '1))
                r_dropped <= r_dropped + 32'd1;
        end
    end

    // Saturating event counters; a clear wins over an increment. The
    // enable used is the one in force before any same-cycle enable write.
    for (genvar g = 0; g < N_CTR; g++) begin : g_ctr
        reg_data_t r_ctr;
        always_ff @(posedge clk) begin
            if (!rstn)
                r_ctr <= '0;
            else if (w_ctr_clear)
                r_ctr <= '0;
            else if (ctr_event[g] && r_ctr_en[g] && (r_ctr != '1))
                r_ctr <= r_ctr + 32'd1;
        end
        assign w_ctr[g] = r_ctr;
    end

    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg_out
        assign cfg_out[32*g +: 32] = r_cfg[g];
    end

    // Read mux over pre-update register values, so a read that coincides
    // with a write or increment returns the old contents.
    always_comb begin
        w_rd_data = UNMAPPED_DATA;
        for (int i = 0; i < N_CFG; i++) begin
            if (w_rword == CFG_WORD + 6'(i)) w_rd_data = r_cfg[i];
        end
        for (int i = 0; i < N_CTR; i++) begin
            if (w_rword == CTR_WORD + 6'(i)) w_rd_data = w_ctr[i];
        end
        if (w_rword == CLEAR_WORD)   w_rd_data = '0;
        if (w_rword == ENABLE_WORD)  w_rd_data = 32'(r_ctr_en);
        if (w_rword == COUNT_WORD)   w_rd_data = 32'(w_dbg_count);
        if (w_rword == POP_WORD)     w_rd_data = (w_dbg_count != '0) ? w_dbg_head : '0;
        if (w_rword == DROPPED_WORD) w_rd_data = r_dropped;
    end

    // Read response: one-cycle pulse, data held between responses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= reg_bus_arvalid;
            if (reg_bus_arvalid) r_rdata <= w_rd_data;
        end
    end

    assign reg_bus_rvalid = r_rvalid;
    assign reg_bus_rdata  = r_rdata;

endmodule

// File: tb/tb_reg_bus_endpoint.sv
// Testbench for reg_bus_endpoint: directed scenarios followed by random
// traffic, with read responses checked against a behavioural model
// through an expected-response queue drained by a monitor process.
module tb_reg_bus_endpoint;

    localparam int N_CFG = 8;
    localparam int N_CTR = 4;
    localparam int LOG_DBG_DEPTH = 4;
    localparam int DEPTH = 16;
    localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 reg_bus_wvalid = 1'b0;
    logic [7:0]           reg_bus_waddr = '0;
    logic [31:0]          reg_bus_wdata = '0;
    logic                 reg_bus_arvalid = 1'b0;
    logic [7:0]           reg_bus_araddr = '0;
    logic                 reg_bus_rvalid;
    logic [31:0]          reg_bus_rdata;
    logic [N_CFG*32-1:0]  cfg_out;
    logic [N_CTR-1:0]     ctr_event = '0;
    logic                 dbg_valid = 1'b0;
    logic [31:0]          dbg_data = '0;

    reg_bus_endpoint #(
        .N_CFG         (N_CFG),
        .N_CTR         (N_CTR),
        .LOG_DBG_DEPTH (LOG_DBG_DEPTH),
        .UNMAPPED_DATA (UNMAPPED)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .reg_bus_wvalid  (reg_bus_wvalid),
        .reg_bus_waddr   (reg_bus_waddr),
        .reg_bus_wdata   (reg_bus_wdata),
        .reg_bus_arvalid (reg_bus_arvalid),
        .reg_bus_araddr  (reg_bus_araddr),
        .reg_bus_rvalid  (reg_bus_rvalid),
        .reg_bus_rdata   (reg_bus_rdata),
        .cfg_out         (cfg_out),
        .ctr_event       (ctr_event),
        .dbg_valid       (dbg_valid),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount = 0;
    int negIdx = 0;

    logic [31:0] expData[$];
    int          expIdx[$];
    string       expName[$];

    // Behavioural model state
    logic [31:0]      mCfg [N_CFG];
    logic [31:0]      mCtr [N_CTR];
    logic [N_CTR-1:0] mEn;
    logic [31:0]      mFifo[$];
    logic [31:0]      mDropped;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CFG; i++) mCfg[i] = '0;
        for (int i = 0; i < N_CTR; i++) mCtr[i] = '0;
        mEn = '1;
        mFifo.delete();
        mDropped = '0;
    endtask

    function automatic logic [31:0] modelRead(input logic [7:0] a);
        int w;
        w = int'(a) / 4;
        if (w < N_CFG) return mCfg[w];
        if (w >= 16 && w < 16 + N_CTR) return mCtr[w - 16];
        case (int'(a) & 'hFC)
            'h60: return 32'h0;
            'h64: return 32'(mEn);
            'h70: return 32'(mFifo.size());
            'h74: return (mFifo.size() > 0) ? mFifo[0] : 32'h0;
            'h78: return mDropped;
            default: return UNMAPPED;
        endcase
    endfunction

    // One clock cycle of the register-map rules, all based on old state.
    task automatic modelCycle(input bit wv, input logic [7:0] wa, input logic [31:0] wd,
                              input bit av, input logic [7:0] aa,
                              input logic [N_CTR-1:0] ev, input bit dv, input logic [31:0] dd);
        int wWord = int'(wa) / 4;
        int rWord = int'(aa) / 4;
        bit popHit = av && (rWord == 'h74 / 4) && (mFifo.size() > 0);
        bit wasFull = (mFifo.size() == DEPTH);
        bit drop = 1'b0;
        bit clr = wv && (wWord == 'h60 / 4);
        logic [N_CTR-1:0] enOld = mEn;
        if (popHit) void'(mFifo.pop_front());
        if (dv) begin
            if (!wasFull || popHit) mFifo.push_back(dd);
            else drop = 1'b1;
        end
        if (wv && wWord == 'h78 / 4) mDropped = '0;
        else if (drop && mDropped != MAXV) mDropped = mDropped + 1;
        for (int i = 0; i < N_CTR; i++) begin
            if (clr) mCtr[i] = '0;
            else if (ev[i] && enOld[i] && mCtr[i] != MAXV) mCtr[i] = mCtr[i] + 1;
        end
        if (wv && wWord < N_CFG) mCfg[wWord] = wd;
        if (wv && wWord == 'h64 / 4) mEn = wd[N_CTR-1:0];
    endtask

    // Drive one cycle of bus traffic, queue the expected read response,
    // advance the model, then return #1 after the sampling edge.
    task automatic applyStimulus(input bit wv, input logic [7:0] wa, input logic [31:0] wd,
                                 input bit av, input logic [7:0] aa,
                                 input logic [N_CTR-1:0] ev, input bit dv, input logic [31:0] dd);
        reg_bus_wvalid  = wv;
        reg_bus_waddr   = wa;
        reg_bus_wdata   = wd;
        reg_bus_arvalid = av;
        reg_bus_araddr  = aa;
        ctr_event       = ev;
        dbg_valid       = dv;
        dbg_data        = dd;
        if (rstn) begin
            if (av) begin
                expData.push_back(modelRead(aa));
                expIdx.push_back(negIdx + 2);
                expName.push_back($sformatf("read 0x%02h", aa));
            end
            modelCycle(wv, wa, wd, av, aa, ev, dv, dd);
        end else begin
            modelReset();
        end
        @(posedge clk);
        #1;
        reg_bus_wvalid  = 1'b0;
        reg_bus_arvalid = 1'b0;
        ctr_event       = '0;
        dbg_valid       = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, '0, 0, 32'h0);
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1, a, d, 0, 8'h0, '0, 0, 32'h0);
    endtask

    task automatic doRead(input logic [7:0] a);
        applyStimulus(0, 8'h0, 32'h0, 1, a, '0, 0, 32'h0);
    endtask

    task automatic checkCfgOut(input string tag);
        for (int i = 0; i < N_CFG; i++)
            checkOutput($sformatf("%s cfg_out[%0d]", tag, i), cfg_out[32*i +: 32], mCfg[i]);
    endtask

    // Monitor: each response must arrive exactly at its expected cycle.
    always @(negedge clk) begin
        negIdx++;
        while (expIdx.size() > 0 && expIdx[0] < negIdx) begin
            checkCount++;
            $display("[TB] FAIL %s: got rvalid=0, expected rvalid=1", expName[0]);
            void'(expIdx.pop_front());
            void'(expData.pop_front());
            void'(expName.pop_front());
        end
        if (reg_bus_rvalid) begin
            if (expIdx.size() > 0 && expIdx[0] == negIdx) begin
                checkOutput(expName[0], reg_bus_rdata, expData[0]);
                void'(expIdx.pop_front());
                void'(expData.pop_front());
                void'(expName.pop_front());
            end else begin
                checkCount++;
                $display("[TB] FAIL unexpected rvalid: got rvalid=1, expected rvalid=0");
            end
        end
    end

    logic [7:0] addrPool [16];

    initial begin
        addrPool = '{8'h00, 8'h04, 8'h08, 8'h1C, 8'h20, 8'h40, 8'h44, 8'h4C,
                     8'h50, 8'h60, 8'h64, 8'h70, 8'h74, 8'h74, 8'h78, 8'h7C};
        modelReset();

        // Reset state
        rstn = 1'b0;
        repeat (3) idle();
        checkOutput("rvalid in reset", {31'b0, reg_bus_rvalid}, 32'h0);
        checkOutput("rdata in reset", reg_bus_rdata, 32'h0);
        checkCfgOut("reset");
        rstn = 1'b1;
        idle();

        // Config write then read back
        doWrite(8'h08, 32'h1234_5678);
        checkOutput("cfg_out[95:64] after write", cfg_out[95:64], 32'h1234_5678);
        doRead(8'h08);
        // Same-cycle read and write of one address returns the old value
        applyStimulus(1, 8'h08, 32'hCAFE_0001, 1, 8'h08, '0, 0, 32'h0);
        doRead(8'h0B);

        // Counter enable gating, then clear racing an event
        repeat (5) applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, 4'b0010, 0, 32'h0);
        doWrite(8'h64, 32'h0);
        repeat (3) applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, 4'b0010, 0, 32'h0);
        doRead(8'h44);
        doWrite(8'h64, 32'hF);
        // Read in the same cycle as an increment sees the old count
        applyStimulus(0, 8'h0, 32'h0, 1, 8'h44, 4'b0010, 0, 32'h0);
        applyStimulus(1, 8'h60, 32'h1, 0, 8'h0, 4'b0010, 0, 32'h0);
        doRead(8'h44);

        // Counter saturation
        force dut.g_ctr[0].r_ctr = 32'hFFFF_FFFE;
        idle();
        release dut.g_ctr[0].r_ctr;
        mCtr[0] = 32'hFFFF_FFFE;
        repeat (3) applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, 4'b0001, 0, 32'h0);
        doRead(8'h40);

        // Debug FIFO overflow and drain
        for (int i = 0; i < 17; i++) applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, '0, 1, 32'(i));
        doRead(8'h70);
        doRead(8'h78);
        for (int i = 0; i < 16; i++) doRead(8'h74);
        doRead(8'h74);
        doRead(8'h70);
        // Push and pop together while empty
        applyStimulus(0, 8'h0, 32'h0, 1, 8'h74, '0, 1, 32'hAAAA_0000);
        doRead(8'h70);
        for (int i = 1; i < 16; i++) applyStimulus(0, 8'h0, 32'h0, 0, 8'h0, '0, 1, 32'hAAAA_0000 + 32'(i));
        // Push and pop together while full
        applyStimulus(0, 8'h0, 32'h0, 1, 8'h74, '0, 1, 32'hBBBB_0000);
        doRead(8'h70);
        doRead(8'h78);
        // Clear of DBG_DROPPED racing a drop
        applyStimulus(1, 8'h78, 32'h0, 0, 8'h0, '0, 1, 32'hCCCC_0000);
        doRead(8'h78);

        // Unmapped, write-only and read-only accesses
        doRead(8'h5C);
        doRead(8'h60);
        doWrite(8'h40, 32'h0000_FFFF);
        doRead(8'h40);
        doWrite(8'h70, 32'h5);
        doRead(8'h70);

        // Reset with a read in flight
        rstn = 1'b0;
        applyStimulus(0, 8'h0, 32'h0, 1, 8'h00, '0, 0, 32'h0);
        checkOutput("rvalid after reset", {31'b0, reg_bus_rvalid}, 32'h0);
        idle();
        rstn = 1'b1;
        checkCfgOut("post-reset");
        idle();
        doRead(8'h70);
        doRead(8'h64);
        doRead(8'h08);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] wa;
            logic [7:0] aa;
            bit wv;
            bit av;
            wa = addrPool[$urandom_range(0, 15)] | 8'($urandom_range(0, 3));
            aa = addrPool[$urandom_range(0, 15)] | 8'($urandom_range(0, 3));
            wv = ($urandom_range(0, 9) < 3);
            if (wa[7:2] == 6'h18) wv = wv && ($urandom_range(0, 7) == 0);
            av = ($urandom_range(0, 1) == 1);
            applyStimulus(wv, wa, $urandom(), av, aa, N_CTR'($urandom_range(0, 15)),
                          ($urandom_range(0, 1) == 1), $urandom());
            if (n % 50 == 49) checkCfgOut("random");
        end

        repeat (4) idle();
        while (expIdx.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL %s: got no response, expected rvalid", expName[0]);
            void'(expIdx.pop_front());
            void'(expData.pop_front());
            void'(expName.pop_front());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/reg_bus_endpoint.md
Name: reg_bus_endpoint

Overview:
Responder end of the per-component register bus driven by the OCL host-interface slave. It owns one component's ID slot: it accepts single-cycle write and read strobes, holds configuration registers, and keeps saturating event counters. It also buffers a debug-word FIFO that the host drains one word per read. It is instantiated inside each component, such as the coalescer, splitter or a core wrapper, with that component's reg_bus_* bit selected.

Parameters:
N_CFG, 8, number of 32-bit config registers (max 16)
N_CTR, 4, number of 32-bit event counters (max 8)
LOG_DBG_DEPTH, 4, debug FIFO depth = 2**LOG_DBG_DEPTH words
UNMAPPED_DATA, 32'hDEAD_BEEF, read data returned for unmapped addresses

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
reg_bus_wvalid  in  1  write strobe for this endpoint, one-cycle pulse
reg_bus_waddr  in  8  write byte address
reg_bus_wdata  in  32  write data
reg_bus_arvalid  in  1  read strobe for this endpoint, one-cycle pulse
reg_bus_araddr  in  8  read byte address
reg_bus_rvalid  out  1  read response valid, one-cycle pulse
reg_bus_rdata  out  32  read response data
cfg_out  out  N_CFG*32  config register contents, cfg i at bits [32i +: 32]
ctr_event  in  N_CTR  per-counter increment strobes
dbg_valid  in  1  push debug word
dbg_data  in  32  debug word

Behaviour:
- Reset is synchronous and active-low (rstn) on clk. During and after reset: cfg_out=0, all counters 0, ctr_enable=all ones, FIFO empty, dropped=0, reg_bus_rvalid=0, reg_bus_rdata=0.
- Address map (byte addresses, bits [1:0] ignored):
  - 0x00+4i: CFG[i], i<N_CFG, read/write.
  - 0x40+4i: CTR[i], i<N_CTR, read-only.
  - 0x60: CTR_CLEAR, write-only; any write clears all counters.
  - 0x64: CTR_ENABLE, read/write; bit i gates counter i.
  - 0x70: DBG_COUNT, read-only; FIFO occupancy.
  - 0x74: DBG_POP, read-only; returns the head word and pops it.
  - 0x78: DBG_DROPPED, read/write; count of pushes lost to a full FIFO. Any write clears it.
- Writes: a write takes effect on the clock edge where wvalid=1, so cfg_out shows the new value the next cycle. Writes to read-only or unmapped addresses are ignored and have no side effect.
- Reads: fixed 1-cycle latency. arvalid in cycle N gives rvalid=1 and rdata in cycle N+1. rvalid is never held for more than one cycle. rdata holds its last value while rvalid=0.
  - Unmapped reads return UNMAPPED_DATA.
  - Reads of write-only registers return 0.
- Counters: a counter increments by 1 when ctr_event[i] and enable[i] are both set. It saturates at 32'hFFFF_FFFF and never wraps.
- Debug FIFO:
  - A push when full is dropped and DBG_DROPPED increments; DBG_DROPPED saturates.
  - Reading DBG_POP when empty returns 0 with no pointer change and no underflow.
  - Pointers wrap modulo the depth. Occupancy uses a LOG_DBG_DEPTH+1-bit count.
- Simultaneous events:
  - Read and write to the same address in the same cycle: the read returns the old value.
  - CTR_CLEAR and ctr_event in the same cycle: the counter ends at 0 (clear wins).
  - A counter read in the same cycle as an increment returns the pre-increment value.
  - Push and pop in the same cycle when full: both occur, the push is accepted and occupancy is unchanged.
  - Push and pop in the same cycle when empty: the pop returns 0 and the push is accepted, so occupancy becomes 1.
  - A DBG_DROPPED write and a drop in the same cycle: the register ends at 0.
- Reset mid-operation: a pending read response is discarded (rvalid=0 in the cycle after reset) and FIFO contents are lost.
- Only one read may be outstanding. arvalid on consecutive cycles is legal and yields back-to-back rvalid pulses. A second back-to-back DBG_POP returns the next word.

Decomposition:
- Shared package (swarm): the REG_EP_* address constants (CFG_BASE, CTR_BASE, CTR_CLEAR, CTR_ENABLE, DBG_COUNT, DBG_POP, DBG_DROPPED) and the reg_data_t typedef (32-bit).
- One sub-module, reg_ep_dbg_fifo: a parameterised synchronous FIFO with push, pop, head, count and full outputs, and pop-when-empty tolerated.
- Decode, counters and the read mux stay in the top module.

Test Plan:
- Write 0x1234_5678 to 0x08, then read 0x08: cfg_out[95:64]=0x1234_5678 one cycle after wvalid; rvalid rises exactly 1 cycle after arvalid with rdata=0x1234_5678.
- Pulse ctr_event[1] 5 times, set CTR_ENABLE=0x0, pulse 3 more times, read 0x44 → 5. Write CTR_CLEAR in the same cycle as an event, read 0x44 → 0.
- Force CTR[0] to 0xFFFF_FFFE, pulse 3 events, read 0x40 → 0xFFFF_FFFF (saturated, no wrap).
- Push 17 words 0..16 into the depth-16 FIFO:
  - DBG_COUNT=16, DBG_DROPPED=1.
  - 16 back-to-back DBG_POP reads return 0..15.
  - A 17th pop returns 0 and DBG_COUNT stays 0.
- Read 0x5C (unmapped) → 0xDEAD_BEEF. Read 0x60 → 0. Write 0x40 with 0xFFFF, then read 0x40 → counter value unchanged.
- Issue arvalid to 0x00, then deassert rstn in the next cycle: rvalid=0, cfg_out=0, FIFO empty after reset. A post-reset read of 0x64 → 0x0000_000F with N_CTR=4.
